// File: rtl/lsm_sequencer.sv
// -----------------------------------------------------------------------------
// lsm_sequencer
//
// Producer side of the load/store-multiple path. It sequences one ARMv4
// LDM/STM instruction. It walks the register list from the lowest register
// to the highest, at ascending word addresses. For each register it issues
// one memory request and drives the register bank controls. When IR[21] asks
// for it, it finishes with an optional base-register writeback strobe.
//
// Ports
//   clk          system clock; all state changes on the rising edge
//   rst          synchronous active-high reset
//   start        one-cycle pulse; latches IR/base_addr when idle
//   IR           instruction: [24]=P [23]=U [21]=W [20]=L [19:16]=Rn [15:0]=list
//   base_addr    value of Rn, sampled together with start
//   mem_ready    memory completes the current transfer this cycle
//   mem_req      transfer request, held until mem_ready
//   mem_we       1 = store (L=0); valid with mem_req
//   mem_addr     address of the current transfer
//   REG_COUNTER  register number of the current transfer
//   LSM_RD_MUX   high while REG_COUNTER selects the transfer register
//   LATCH_REG    load write strobe: mem_req && mem_ready && L
//   WRITE_BACK   one-cycle base writeback strobe
//   wb_value     new base value, valid while WRITE_BACK
//   busy         high from the cycle after start through the done cycle
//   done         one-cycle completion pulse
// -----------------------------------------------------------------------------
module lsm_sequencer #(
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       IR,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        REG_COUNTER,
    output logic              LSM_RD_MUX,
    output logic              LATCH_REG,
    output logic              WRITE_BACK,
    output logic [ADDR_W-1:0] wb_value,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_WB,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

    // Number of registers in a 16-bit list, 0..16.
    function automatic logic [4:0] count_ones(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // Index of the lowest set bit; 0 for an empty list (never used as a transfer).
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    state_t            state;
    logic [15:0]       list_q;      // registers still to transfer
    logic              p_q;
    logic              u_q;
    logic              l_q;
    logic              wb_en_q;     // W set and not overridden by a load of Rn
    logic [ADDR_W-1:0] base_q;

    logic [15:0]       ir_list;
    logic              rn_listed;
    logic [4:0]        n_regs;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] first_addr;
    logic [15:0]       remaining;

    // Only the fields above are meaningful to the sequencer.
    logic              unused_ir;
    assign unused_ir = ^{IR[31:25], IR[22]};

    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    always_comb begin
        ir_list    = IR[15:0];
        rn_listed  = ir_list[IR[19:16]];
        n_regs     = count_ones(list_q);
        span       = ADDR_W'(n_regs) * STEP;
        remaining  = list_q & ~(16'h0001 << REG_COUNTER);
        first_addr = base_q;
        // The lowest address always goes to the lowest register, so decrementing
        // modes start below the base and still count upward.
        case ({p_q, u_q})
            2'b01:   first_addr = base_q;                 // IA
            2'b11:   first_addr = base_q + STEP;          // IB
            2'b00:   first_addr = base_q - span + STEP;   // DA
            default: first_addr = base_q - span;          // DB
        endcase
    end

    // Completion of a load is visible to the register bank in the same cycle.
    assign LATCH_REG = mem_req & mem_ready & l_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            list_q      <= '0;
            p_q         <= 1'b0;
            u_q         <= 1'b0;
            l_q         <= 1'b0;
            wb_en_q     <= 1'b0;
            base_q      <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            REG_COUNTER <= '0;
            LSM_RD_MUX  <= 1'b0;
            WRITE_BACK  <= 1'b0;
            wb_value    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done       <= 1'b0;
            WRITE_BACK <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        list_q  <= IR[15:0];
                        p_q     <= IR[24];
                        u_q     <= IR[23];
                        l_q     <= IR[20];
                        // A load of the base register wins over the writeback.
                        wb_en_q <= IR[21] & ~(IR[20] & rn_listed);
                        base_q  <= base_addr;
                        busy    <= 1'b1;
                        state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    wb_value <= u_q ? (base_q + span) : (base_q - span);
                    if (n_regs == 5'd0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        mem_req     <= 1'b1;
                        mem_we      <= ~l_q;
                        LSM_RD_MUX  <= 1'b1;
                        mem_addr    <= first_addr;
                        REG_COUNTER <= lowest_set(list_q);
                        state       <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (mem_ready) begin
                        list_q      <= remaining;
                        mem_addr    <= mem_addr + STEP;
                        REG_COUNTER <= lowest_set(remaining);
                        if (remaining == 16'h0000) begin
                            mem_req    <= 1'b0;
                            mem_we     <= 1'b0;
                            LSM_RD_MUX <= 1'b0;
                            if (wb_en_q) begin
                                WRITE_BACK <= 1'b1;
                                state      <= S_WB;
                            end else begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end
                        end
                    end
                end
                S_WB: begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lsm_sequencer
//
// Self-checking bench for lsm_sequencer. For each instruction, a reference
// model builds the expected per-cycle timeline from the instruction fields:
// the transfer list, the addresses, the stall pattern, writeback and done.
// The DUT is then compared against that timeline two time units after each
// rising edge.
// -----------------------------------------------------------------------------
module tb_lsm_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] IR;
    logic [31:0] base_addr;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  REG_COUNTER;
    logic        LSM_RD_MUX;
    logic        LATCH_REG;
    logic        WRITE_BACK;
    logic [31:0] wb_value;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    lsm_sequencer #(.ADDR_W(32), .WORD_BYTES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .IR          (IR),
        .base_addr   (base_addr),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .REG_COUNTER (REG_COUNTER),
        .LSM_RD_MUX  (LSM_RD_MUX),
        .LATCH_REG   (LATCH_REG),
        .WRITE_BACK  (WRITE_BACK),
        .wb_value    (wb_value),
        .busy        (busy),
        .done        (done)
    );

    // One expected cycle of the timeline.
    typedef struct {
        bit          req;
        bit          ready;
        int          rg;
        logic [31:0] addr;
        bit          wb;
        bit          done;
        bit          busy;
    } cyc_t;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Moves to the start of the next cycle (one unit after the rising edge).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] make_ir(input bit p, input bit u, input bit w,
                                            input bit l, input logic [3:0] rn,
                                            input logic [15:0] list);
        return {4'hE, 3'b100, p, u, 1'b0, w, l, rn, list};
    endfunction

    task automatic check_idle_outputs(input string pfx);
        check({pfx, " mem_req"},     32'(mem_req),     32'd0);
        check({pfx, " mem_we"},      32'(mem_we),      32'd0);
        check({pfx, " mem_addr"},    mem_addr,         32'd0);
        check({pfx, " REG_COUNTER"}, 32'(REG_COUNTER), 32'd0);
        check({pfx, " LSM_RD_MUX"},  32'(LSM_RD_MUX),  32'd0);
        check({pfx, " LATCH_REG"},   32'(LATCH_REG),   32'd0);
        check({pfx, " WRITE_BACK"},  32'(WRITE_BACK),  32'd0);
        check({pfx, " wb_value"},    wb_value,         32'd0);
        check({pfx, " busy"},        32'(busy),        32'd0);
        check({pfx, " done"},        32'(done),        32'd0);
    endtask

    // Runs one instruction against the model timeline.
    //   stall_fixed/stall_rand: wait cycles before each transfer completes
    //   poke_start: pulse start randomly while the DUT is busy (must be ignored)
    task automatic run_op(input int id, input logic [31:0] ir, input logic [31:0] base,
                          input int stall_fixed, input int stall_rand, input bit poke_start);
        bit          p;
        bit          u;
        bit          w;
        bit          l;
        logic [3:0]  rn;
        logic [15:0] list;
        int          regs[$];
        int          n;
        int          stalls;
        int          done_c;
        bit          wb_on;
        logic [31:0] wb_exp;
        logic [31:0] low;
        cyc_t        sched[$];
        cyc_t        cy;
        string       pfx;

        p    = ir[24];
        u    = ir[23];
        w    = ir[21];
        l    = ir[20];
        rn   = ir[19:16];
        list = ir[15:0];
        for (int i = 0; i < 16; i++) begin
            if (list[i]) regs.push_back(i);
        end
        n = regs.size();

        // Architectural block-transfer rules: the lowest register uses the
        // lowest address of the block, and the new base moves by 4 per register.
        wb_on  = (n > 0) && w && !(l && list[rn]);
        wb_exp = u ? base + 32'(4 * n) : base - 32'(4 * n);
        if (u) low = base + (p ? 32'd4 : 32'd0);
        else   low = base - 32'(4 * n) + (p ? 32'd0 : 32'd4);

        cy = '{default: 0};
        sched.push_back(cy);                    // start cycle, DUT still idle
        cy.busy = 1'b1;
        sched.push_back(cy);                    // setup
        for (int k = 0; k < n; k++) begin
            stalls  = stall_fixed + int'($urandom_range(stall_rand, 0));
            cy      = '{default: 0};
            cy.busy = 1'b1;
            cy.req  = 1'b1;
            cy.rg   = regs[k];
            cy.addr = low + 32'(4 * k);
            cy.ready = 1'b0;
            repeat (stalls) sched.push_back(cy);
            cy.ready = 1'b1;
            sched.push_back(cy);
        end
        if (wb_on) begin
            cy      = '{default: 0};
            cy.busy = 1'b1;
            cy.wb   = 1'b1;
            sched.push_back(cy);
        end
        cy      = '{default: 0};
        cy.busy = 1'b1;
        cy.done = 1'b1;
        sched.push_back(cy);
        done_c = sched.size() - 1;
        cy = '{default: 0};
        sched.push_back(cy);                    // busy must drop here
        sched.push_back(cy);                    // and stay low

        IR        = ir;
        base_addr = base;
        for (int c = 0; c < sched.size(); c++) begin
            next_cycle();
            start = (c == 0) ||
                    (poke_start && c > 0 && c <= done_c && $urandom_range(1, 0) == 1);
            // Outside transfers mem_ready is noise the DUT must ignore.
            mem_ready = sched[c].req ? sched[c].ready : 1'($urandom_range(1, 0));
            if (c > 0) begin
                IR        = $urandom;
                base_addr = $urandom;
            end
            #1;
            pfx = $sformatf("op%0d c%0d", id, c);
            check({pfx, " mem_req"},    32'(mem_req),    32'(sched[c].req));
            check({pfx, " busy"},       32'(busy),       32'(sched[c].busy));
            check({pfx, " done"},       32'(done),       32'(sched[c].done));
            check({pfx, " WRITE_BACK"}, 32'(WRITE_BACK), 32'(sched[c].wb));
            check({pfx, " LATCH_REG"},  32'(LATCH_REG),
                  32'(sched[c].req && sched[c].ready && l));
            if (sched[c].req) begin
                check({pfx, " REG_COUNTER"}, 32'(REG_COUNTER), 32'(sched[c].rg));
                check({pfx, " mem_addr"},    mem_addr,         sched[c].addr);
                check({pfx, " mem_we"},      32'(mem_we),      32'(!l));
                check({pfx, " LSM_RD_MUX"},  32'(LSM_RD_MUX),  32'd1);
            end
            if (sched[c].wb) begin
                check({pfx, " wb_value"}, wb_value, wb_exp);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] ir;
        logic [31:0] base;

        rst       = 1'b1;
        start     = 1'b0;
        IR        = '0;
        base_addr = '0;
        mem_ready = 1'b0;

        // Reset state.
        repeat (3) next_cycle();
        #1;
        check_idle_outputs("reset");
        next_cycle();
        rst = 1'b0;

        // LDMIA R0, {R1,R2,R4}: addresses 0x1000.., loads, no writeback, done at +5.
        run_op(1, make_ir(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 16'h0016), 32'h0000_1000, 0, 0, 1'b0);

        // STMDB R13!, {R0,R1,R14}: 0x1FF4..0x1FFC, writeback 0x1FF4.
        run_op(2, make_ir(1'b1, 1'b0, 1'b1, 1'b0, 4'd13, 16'h4003), 32'h0000_2000, 0, 0, 1'b0);

        // LDMIB R3!, {R3..R7}: first address base+4, writeback suppressed.
        run_op(3, make_ir(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 16'h00F8), 32'h0000_3000, 0, 0, 1'b0);

        // STMIB R3!, {R3..R7}: a store of the base still writes back.
        run_op(4, make_ir(1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 16'h00F8), 32'h0000_3000, 0, 0, 1'b0);

        // STMIA, single register, memory stalls three cycles.
        run_op(5, make_ir(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 16'h0001), 32'h0000_4000, 3, 0, 1'b0);

        // Empty list with W=1: no transfer, no writeback, done two cycles after start.
        run_op(6, make_ir(1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 16'h0000), 32'h0000_5000, 0, 0, 1'b0);

        // STMDA R0!, {R0-R15} at 0x40: 0x04..0x40, writeback 0x00.
        run_op(7, make_ir(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'hFFFF), 32'h0000_0040, 0, 0, 1'b0);

        // Wrap-around below zero with an unaligned base; start pokes while busy.
        run_op(8, make_ir(1'b1, 1'b0, 1'b1, 1'b1, 4'd9, 16'h8101), 32'h0000_0006, 1, 1, 1'b1);

        // Reset during the second transfer aborts cleanly.
        next_cycle();
        IR        = make_ir(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 16'h0016);
        base_addr = 32'h0000_1000;
        start     = 1'b1;
        mem_ready = 1'b1;
        next_cycle();                   // setup
        start = 1'b0;
        next_cycle();                   // first transfer (R1)
        next_cycle();                   // second transfer (R2)
        #1;
        check("rstmid REG_COUNTER before", 32'(REG_COUNTER), 32'd2);
        check("rstmid mem_addr before",    mem_addr,         32'h0000_1004);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        check_idle_outputs("rstmid after");
        next_cycle();
        #1;
        check("rstmid idle busy",    32'(busy),    32'd0);
        check("rstmid idle mem_req", 32'(mem_req), 32'd0);

        // A fresh operation after the abort runs normally.
        run_op(9, make_ir(1'b0, 1'b1, 1'b1, 1'b1, 4'd12, 16'h0016), 32'h0000_1000, 0, 0, 1'b1);

        // Randomized instructions, bases and stall patterns.
        for (int t = 0; t < 40; t++) begin
            ir   = $urandom;
            base = $urandom;
            if (t % 5 == 0) ir[15:0] = ir[15:0] & 16'h0101;
            if (t % 7 == 0) ir[15:0] = 16'h0000;
            run_op(100 + t, ir, base, 0, 2, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lsm_sequencer.md
Name: lsm_sequencer

Overview:
Multi-cycle sequencer for ARMv4 LDM/STM (block data transfer) instructions. It is the producer side of the register bank's load/store-multiple path: it walks the IR register list in ascending order and drives REG_COUNTER and LSM_RD_MUX into the register bank encapsulation. For each transfer it generates the word address and the memory request handshake. It asserts LATCH_REG on each load and WRITE_BACK for base update when IR[21] is set.

Parameters:
ADDR_W, 32, address/data width
WORD_BYTES, 4, address increment per transfer

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; latch IR/base and begin; ignored while busy
IR  input  32  instruction; uses [24]=P, [23]=U, [21]=W, [20]=L, [19:16]=Rn, [15:0]=list
base_addr  input  32  value of Rn, sampled with start
mem_ready  input  1  memory completes current transfer this cycle
mem_req  output  1  transfer request, held until mem_ready
mem_we  output  1  1=store (L=0), valid with mem_req
mem_addr  output  32  word address of current transfer
REG_COUNTER  output  4  register number of current transfer
LSM_RD_MUX  output  1  high while REG_COUNTER selects Rd
LATCH_REG  output  1  load write strobe, high on the cycle mem_req&&mem_ready&&L
WRITE_BACK  output  1  one-cycle base writeback strobe
wb_value  output  32  new base value, valid while WRITE_BACK
busy  output  1  high from the cycle after start until the DONE cycle inclusive
done  output  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE. All outputs 0, including mem_addr, wb_value and REG_COUNTER. Latched list cleared. rst mid-operation aborts in the next cycle with no further strobes.
- States: IDLE, SETUP, XFER, WB, DONE.
- IDLE: on start, latch list=IR[15:0], P/U/W/L, Rn, base. Go to SETUP.
- SETUP (1 cycle): n=popcount(list), a 5-bit value 0..16. Start address:
  - IA (P=0,U=1): base
  - IB (P=1,U=1): base+4
  - DA (P=0,U=0): base-4n+4
  - DB (P=1,U=0): base-4n
  - wb_value = U ? base+4n : base-4n.
  - All arithmetic is mod 2^32.
  - n=0: go to DONE with no transfers and no writeback.
  - Otherwise go to XFER with REG_COUNTER = lowest set bit.
- XFER:
  - mem_req=1, LSM_RD_MUX=1, mem_we=~L.
  - Registers always go in ascending order at ascending addresses.
  - While mem_ready=0, hold all outputs stable.
  - On mem_ready=1: clear the current bit and add 4 to mem_addr.
  - If bits remain: next REG_COUNTER = next lowest set bit, stay in XFER with no idle bubble.
  - Else go to WB if W=1 and not suppressed; otherwise go to DONE.
- WB suppression: if L=1 and Rn is in the list, writeback is suppressed (the loaded value wins). STM with Rn in the list still writes back.
- WB: WRITE_BACK=1 for 1 cycle with wb_value, then DONE.
- DONE: done=1 for 1 cycle, then IDLE. busy drops the following cycle.
- Latency with mem_ready tied high:
  - first mem_req occurs 2 cycles after start.
  - total from start to done = n+2 cycles, +1 if writeback.
- start asserted while busy is ignored. start in the DONE cycle is ignored.
- R15 in the list is treated like any other register; the PC side effect is handled downstream.
- mem_addr is word-aligned only if base is aligned. Low bits pass through unmodified.

Test Plan:
- LDMIA, base=0x1000, list=0x0016 (R1,R2,R4), W=0, mem_ready=1 -> REG_COUNTER 1,2,4 at addrs 0x1000,0x1004,0x1008; LATCH_REG on all 3; no WRITE_BACK; done 5 cycles after start.
- STMDB, base=0x2000, list=0x4003 (R0,R1,R14), W=1 -> mem_we=1; addrs 0x1FF4,0x1FF8,0x1FFC; WRITE_BACK with wb_value=0x1FF4; LATCH_REG never high.
- LDMIB, W=1, Rn=3, list includes R3 -> first addr base+4; WRITE_BACK suppressed; done still pulses.
- STMIA, list=0x0001, mem_ready low 3 cycles then high -> mem_req/addr/REG_COUNTER stable for 4 cycles; exactly one transfer.
- list=0x0000 -> no mem_req, no WRITE_BACK; done 2 cycles after start. list=0xFFFF DA, base=0x40 -> first addr 0x04, last 0x40, wb_value 0x00.
- rst asserted during the second transfer -> next cycle all outputs 0, state IDLE. A new start then runs normally. start pulsed mid-transfer is ignored.
